// File: rtl/priority_arbiter.sv
// priority_arbiter: registered N-input request arbiter with a sticky one-hot
// grant, valid/ready acceptance, and fixed-priority or round-robin selection.
// MODE 0 gives the highest requesting index the win. MODE 1 searches upward
// from a rotating pointer, so the requester just accepted ranks lowest next.
module priority_arbiter #(
    parameter int  N    = 8,
    parameter int  MODE = 0,
    localparam int W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] gnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [W:0]   L_N    = (W+1)'(N);
    localparam logic [W-1:0] L_LAST = W'(N - 1);
    localparam logic [N-1:0] L_ONE  = N'(1);

    state_t       r_state, w_state_nxt;
    logic         r_valid, w_valid_nxt;
    logic [W-1:0] r_idx, w_idx_nxt;
    logic [W-1:0] r_ptr, w_ptr_nxt;
    logic [N-1:0] r_gnt, w_gnt_nxt;

    logic         w_accept;
    logic         w_any;
    logic [W-1:0] w_ptr_eff;
    logic [W-1:0] w_win, w_win_hi, w_win_rr, w_off;
    logic [N-1:0] w_rot;
    logic [W:0]   w_sum;

    // Increment modulo N, so a non-power-of-two N never reaches the unused
    // index codes.
    function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
        if (v == L_LAST) return '0;
        return v + W'(1);
    endfunction

    assign w_any    = |req;
    assign w_accept = (r_state == GRANT) && ready;

    // On an accept the pointer moves past the retiring index. The search in
    // that same cycle must already use the moved pointer.
    assign w_ptr_eff = (MODE == 1 && w_accept) ? wrap_inc(r_idx) : r_ptr;

    // Winner selection: the highest set bit, or the first set bit at or after
    // the pointer with wrap-around.
    always_comb begin
        w_win_hi = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) w_win_hi = W'(i);
        end
        // Rotate req so that the pointer position lands at bit 0. The lowest
        // set bit of the rotated vector is then the offset from the pointer.
        w_rot = N'({req, req} >> w_ptr_eff);
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = W'(k);
        end
        w_sum = {1'b0, w_ptr_eff} + {1'b0, w_off};
        if (w_sum >= L_N) w_sum = w_sum - L_N;
        w_win_rr = w_sum[W-1:0];
        w_win    = (MODE == 1) ? w_win_rr : w_win_hi;
    end

    // Next-state logic. A held grant ignores req until it is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_valid_nxt = 1'b1;
                    w_idx_nxt   = w_win;
                    w_gnt_nxt   = L_ONE << w_win;
                end
            end
            GRANT: begin
                if (ready) begin
                    w_ptr_nxt = w_ptr_eff;
                    if (w_any) begin
                        w_idx_nxt = w_win;
                        w_gnt_nxt = L_ONE << w_win;
                    end else begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers. The synchronous reset takes priority over
    // an accept in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign valid = r_valid;
    assign idx   = r_idx;
    assign gnt   = r_gnt;

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

- Parametrised, registered N-input priority encoder with a grant/accept handshake and a selectable fixed-priority or round-robin mode.
- Successor to the 4-to-2 combinational priority encoder; serves as the request arbiter in front of shared resources such as a bus, a memory port or an output queue.
- Selects one active request, presents its index and a one-hot grant, and holds that grant stable until the consumer accepts it.

## Interface
- N, 8: number of request inputs; legal range 2..64; need not be a power of two.
- W, $clog2(N): index width; derived, never overridden.
- MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- req  input  N  request vector; bit i high means requester i wants a grant.
- ready  input  1  consumer accepts the current grant in any cycle where valid && ready.
- valid  output  1  a grant is presented.
- idx  output  W  binary index of the granted requester.
- gnt  output  N  one-hot grant; equals 1 << idx when valid, all zero otherwise.

## Operation
- State machine has two states: IDLE (valid = 0) and GRANT (valid = 1).
- IDLE:
  - If |req, register the winner (idx, gnt, valid = 1) and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT with ready = 0:
  - idx and gnt hold unchanged.
  - They hold even if req changes, including when the granted bit drops. The grant is sticky.
- GRANT with ready = 1 (accept):
  - The grant retires.
  - In MODE 1, the pointer ptr updates to (idx + 1) mod N.
  - If |req in the same cycle, register a new winner from the current req and stay in GRANT (back-to-back, no bubble).
  - If req is all zero, valid drops and the block goes to IDLE.
- Winner selection, MODE 0: highest set bit of req. ptr is unused.
- Winner selection, MODE 1:
  - Search req ascending from ptr, wrapping from N-1 to 0; the first set bit wins.
  - The pointer value used is the one taking effect at the same edge, i.e. (idx + 1) mod N on an accept.
  - A requester that was just accepted therefore has lowest priority next.
- Wrap arithmetic is mod N, not mod 2^W. For non-power-of-two N, idx never exceeds N-1 and req bits above N-1 do not exist.
- Reset (synchronous, rst_n = 0 at an edge):
  - valid = 0, idx = 0, gnt = 0, ptr = 0, state IDLE.
  - Reset overrides every other condition, including an accept in the same cycle and reset during GRANT.
- No combinational path from req or ready to any output.

## Timing
- Latency: req sampled at edge k → valid, idx and gnt visible after edge k (1 cycle).
- Throughput: one grant per cycle when ready is held high and requests persist.
- Outputs change only on rising edges of clk.
- Reset values: valid 0, idx 0, gnt 0.
- The first edge with rst_n = 1 after reset may already register a grant if |req.
- ready while valid = 0 is ignored and has no effect on ptr.
- Simultaneous req withdrawal and accept: the accept completes; the next winner is taken from that cycle's req.
- No winner in that cycle means IDLE.

## Test plan
- Reset priority: N=8, req=8'hFF, rst_n=0 for 2 edges → valid=0, idx=0, gnt=0. Release rst_n, MODE=1 → next edge idx=0, gnt=8'h01.
- Fixed hold: MODE=0, N=8, req=8'b0010_0110, ready=0 → valid=1, idx=5, gnt=8'h20. Then change req to 8'h01 for 3 cycles → idx stays 5. Assert ready → next idx=0.
- Round-robin sweep: MODE=1, N=8, req=8'hFF, ready=1 continuously → idx sequence 0,1,2,3,4,5,6,7,0, one per cycle, valid never drops.
- Fairness: MODE=1, N=8, req=8'b1000_0001, ready=1 → idx alternates 0,7,0,7. In MODE=0 with the same stimulus → idx=7 every cycle.
- Non-power-of-two: MODE=1, N=5, req=5'b10001, ready=1 → idx 0,4,0,4; ptr wraps from 4 to 0, never to 5..7.
- Reset mid-grant and drain: MODE=1, N=8, grant presented with idx=3. Drive rst_n=0 with ready=1 → next edge valid=0, gnt=0. Then req=8'h0C → idx=2 (ptr restarted at 0). Then req=0 with ready=1 → valid=0 next edge, state IDLE.
